// File: rtl/nasti_lite_pkg.sv
// Shared types for the NASTI-lite read packer: FSM state encoding and AXI response codes.
package nasti_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  // Worst-case merge: a larger code is a more severe response.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nasti_lite_cmd_fifo.sv
// Command FIFO for the read packer; ready is derived only from the occupancy count.
module nasti_lite_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle does not free a slot for a push at full.
  assign push_ready = (count != CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nasti_lite_r_packer.sv
// Packs RATIO narrow lite read beats into one NASTI read beat per command burst.
// Define NASTI_LITE_R_PACKER_USER_EN to forward the last lane's user bits.
module nasti_lite_r_packer
  import nasti_lite_pkg::*;
#(
  parameter int ID_WIDTH         = 1,
  parameter int NASTI_DATA_WIDTH = 32,
  parameter int LITE_DATA_WIDTH  = 8,
  parameter int USER_WIDTH       = 1,
  parameter int CMD_DEPTH        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         cmd_id,
  input  logic [7:0]                  cmd_len,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  input  logic [1:0]                  lite_r_resp,
  input  logic [USER_WIDTH-1:0]       lite_r_user,
  input  logic                        lite_r_valid,
  output logic                        lite_r_ready,
  output logic [ID_WIDTH-1:0]         nasti_r_id,
  output logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  output logic [1:0]                  nasti_r_resp,
  output logic                        nasti_r_last,
  output logic [USER_WIDTH-1:0]       nasti_r_user,
  output logic                        nasti_r_valid,
  input  logic                        nasti_r_ready
);

  localparam int RATIO = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a source holds its payload stable while valid is high and ready is low.

  state_t                      state;
  state_t                      state_nxt;
  logic [ID_WIDTH-1:0]         head_id;
  logic [7:0]                  head_len;
  logic                        fifo_empty;
  logic                        cmd_pop;
  logic [ID_WIDTH-1:0]         cur_id;
  logic [7:0]                  cur_len;
  logic [7:0]                  beat_cnt;
  logic [LW-1:0]               lane_cnt;
  logic [NASTI_DATA_WIDTH-1:0] data_q;
  logic [1:0]                  resp_q;
  logic                        lane_last;
  logic                        is_last;

  nasti_lite_cmd_fifo #(
    .WIDTH (ID_WIDTH + 8),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  ({cmd_id, cmd_len}),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .pop        (cmd_pop),
    .head_data  ({head_id, head_len}),
    .empty      (fifo_empty)
  );

  assign lane_last = (lane_cnt == LW'(RATIO - 1));
  assign is_last   = (beat_cnt == cur_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    lite_r_ready  = 1'b0;
    nasti_r_valid = 1'b0;
    cmd_pop       = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_FILL;
      ST_FILL: begin
        lite_r_ready = 1'b1;
        if (lite_r_valid && lane_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        nasti_r_valid = 1'b1;
        if (nasti_r_ready) begin
          cmd_pop   = is_last;
          state_nxt = is_last ? ST_IDLE : ST_FILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // data_q doubles as the lane accumulator; it only changes outside HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id   <= '0;
      cur_len  <= '0;
      beat_cnt <= '0;
      lane_cnt <= '0;
      data_q   <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          cur_id   <= head_id;
          cur_len  <= head_len;
          beat_cnt <= '0;
          lane_cnt <= '0;
          data_q   <= '0;
          resp_q   <= RESP_OKAY;
        end
        ST_FILL: if (lite_r_valid) begin
          data_q[lane_cnt*LITE_DATA_WIDTH +: LITE_DATA_WIDTH] <= lite_r_data;
          resp_q   <= resp_max(resp_q, lite_r_resp);
          lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
        end
        ST_HOLD: if (nasti_r_ready && !is_last) begin
          beat_cnt <= beat_cnt + 1'b1;
          data_q   <= '0;
          resp_q   <= RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  assign nasti_r_id   = cur_id;
  assign nasti_r_data = data_q;
  assign nasti_r_resp = resp_q;
  assign nasti_r_last = (state == ST_HOLD) && is_last;

`ifdef NASTI_LITE_R_PACKER_USER_EN
  logic [USER_WIDTH-1:0] user_q;

  // Written on every lane so the value left in HOLD is the last lane's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 user_q <= '0;
    else if (state == ST_FILL && lite_r_valid) user_q <= lite_r_user;
  end

  assign nasti_r_user = user_q;
`else
  logic unused_user;
  assign unused_user  = ^lite_r_user;
  assign nasti_r_user = '0;
`endif

endmodule

// File: tb/tb_nasti_lite_r_packer.sv
// Directed bench for nasti_lite_r_packer (32-bit NASTI, 8-bit lite, 2-entry command FIFO).
module tb_nasti_lite_r_packer;

  localparam int IDW = 1;
  localparam int NW  = 32;
  localparam int LDW = 8;
  localparam int UW  = 1;
  localparam int BW  = IDW + NW + 2 + 1 + UW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_id = 1'b0;
  logic [7:0]     cmd_len = 8'd0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [LDW-1:0] lite_r_data = '0;
  logic [1:0]     lite_r_resp = 2'd0;
  logic [UW-1:0]  lite_r_user = '0;
  logic           lite_r_valid = 1'b0;
  logic           lite_r_ready;
  logic [IDW-1:0] nasti_r_id;
  logic [NW-1:0]  nasti_r_data;
  logic [1:0]     nasti_r_resp;
  logic           nasti_r_last;
  logic [UW-1:0]  nasti_r_user;
  logic           nasti_r_valid;
  logic           nasti_r_ready = 1'b1;

  nasti_lite_r_packer #(
    .ID_WIDTH         (IDW),
    .NASTI_DATA_WIDTH (NW),
    .LITE_DATA_WIDTH  (LDW),
    .USER_WIDTH       (UW),
    .CMD_DEPTH        (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_id        (cmd_id),
    .cmd_len       (cmd_len),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .lite_r_data   (lite_r_data),
    .lite_r_resp   (lite_r_resp),
    .lite_r_user   (lite_r_user),
    .lite_r_valid  (lite_r_valid),
    .lite_r_ready  (lite_r_ready),
    .nasti_r_id    (nasti_r_id),
    .nasti_r_data  (nasti_r_data),
    .nasti_r_resp  (nasti_r_resp),
    .nasti_r_last  (nasti_r_last),
    .nasti_r_user  (nasti_r_user),
    .nasti_r_valid (nasti_r_valid),
    .nasti_r_ready (nasti_r_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_beat(input logic id, input logic [31:0] data,
                                              input logic [1:0] resp, input logic last,
                                              input logic user);
    return {id, data, resp, last, user};
  endfunction

  function automatic logic exp_user(input logic u);
`ifdef NASTI_LITE_R_PACKER_USER_EN
    return u;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && nasti_r_valid && nasti_r_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: actual=data %0h required=no beat", nasti_r_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("r_id",   32'(nasti_r_id),   32'(mon_e[36]));
        check("r_data", nasti_r_data,      mon_e[35:4]);
        check("r_resp", 32'(nasti_r_resp), 32'(mon_e[3:2]));
        check("r_last", 32'(nasti_r_last), 32'(mon_e[1]));
        check("r_user", 32'(nasti_r_user), 32'(mon_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic id, input logic [7:0] len);
    int n = 0;
    cmd_id    = id;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_push_timeout: actual=cmd_ready 0 required=1");
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_lite(input logic [7:0] d, input logic [1:0] r, input logic u);
    int n = 0;
    lite_r_data  = d;
    lite_r_resp  = r;
    lite_r_user  = u;
    lite_r_valid = 1'b1;
    while (!lite_r_ready && n < 50) begin tick(); n++; end
    if (!lite_r_ready) begin
      n_checks++; n_fail++;
      $display("FAIL lite_timeout: actual=lite_r_ready 0 required=1");
    end
    tick();
    lite_r_valid = 1'b0;
  endtask

  task automatic wait_beat;
    int n = 0;
    while (!(nasti_r_valid && nasti_r_ready) && n < 50) begin tick(); n++; end
    if (!(nasti_r_valid && nasti_r_ready)) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: actual=nasti_r_valid %0b required=1", nasti_r_valid);
    end
    tick();
  endtask

  // ---------------- vectors ----------------
  // lite_d lists lanes in send order, first lane in bits [31:24]; likewise resp/user.
  typedef struct {
    logic        push;
    logic        id;
    logic [7:0]  len;
    logic [31:0] lite_d;
    logic [7:0]  lite_resp;
    logic [3:0]  lite_user;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_last;
    logic        exp_user_on;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic any_valid;
    logic [7:0] bb;

    vecs[0] = '{1'b1, 1'b1, 8'd0, 32'h11223344, 8'b00_00_00_00, 4'b0000, 32'h44332211, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd1, 32'hAABBCCDD, 8'b00_00_10_00, 4'b0000, 32'hDDCCBBAA, 2'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'd1, 32'h01020304, 8'b00_00_00_00, 4'b0000, 32'h04030201, 2'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'd0, 32'hF00F5AA5, 8'b01_00_00_00, 4'b0001, 32'hA55A0FF0, 2'd1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 32'h000000FF, 8'b11_01_10_00, 4'b1110, 32'hFF000000, 2'd3, 1'b1, 1'b0};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",      32'(nasti_r_valid), 32'd0);
    check("rst_lite_ready", 32'(lite_r_ready),  32'd0);
    check("rst_cmd_ready",  32'(cmd_ready),     32'd1);
    check("rst_data",       nasti_r_data,       32'd0);
    check("rst_id",         32'(nasti_r_id),    32'd0);
    check("rst_last",       32'(nasti_r_last),  32'd0);
    rst = 1'b0;
    tick();

    // table-driven bursts
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].push) push_cmd(vecs[i].id, vecs[i].len);
      exp_q.push_back(pack_beat(vecs[i].id, vecs[i].exp_data, vecs[i].exp_resp,
                                vecs[i].exp_last, exp_user(vecs[i].exp_user_on)));
      for (int k = 0; k < 4; k++)
        send_lite(vecs[i].lite_d[31-8*k -: 8], vecs[i].lite_resp[7-2*k -: 2], vecs[i].lite_user[3-k]);
      check("valid_after_last_lane", 32'(nasti_r_valid), 32'd1);
      check("lite_ready_in_hold",    32'(lite_r_ready),  32'd0);
      wait_beat();
    end

    // downstream stall holds the beat stable
    push_cmd(1'b1, 8'd0);
    exp_q.push_back(pack_beat(1'b1, 32'h78563412, 2'd0, 1'b1, exp_user(1'b0)));
    nasti_r_ready = 1'b0;
    send_lite(8'h12, 2'd0, 1'b0);
    send_lite(8'h34, 2'd0, 1'b0);
    send_lite(8'h56, 2'd0, 1'b0);
    send_lite(8'h78, 2'd0, 1'b0);
    lite_r_data  = 8'hEE;
    lite_r_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid",      32'(nasti_r_valid), 32'd1);
      check("stall_data",       nasti_r_data,       32'h78563412);
      check("stall_id",         32'(nasti_r_id),    32'd1);
      check("stall_last",       32'(nasti_r_last),  32'd1);
      check("stall_lite_ready", 32'(lite_r_ready),  32'd0);
      tick();
    end
    lite_r_valid  = 1'b0;
    nasti_r_ready = 1'b1;
    wait_beat();

    // command FIFO full: third command waits for the first burst's final handshake
    push_cmd(1'b1, 8'd0);
    push_cmd(1'b0, 8'd0);
    cmd_id    = 1'b1;
    cmd_len   = 8'd0;
    cmd_valid = 1'b1;
    check("fifo_full_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("fifo_full_ready_hold", 32'(cmd_ready), 32'd0);
    exp_q.push_back(pack_beat(1'b1, 32'h04030201, 2'd0, 1'b1, exp_user(1'b0)));
    send_lite(8'h01, 2'd0, 1'b0);
    send_lite(8'h02, 2'd0, 1'b0);
    send_lite(8'h03, 2'd0, 1'b0);
    send_lite(8'h04, 2'd0, 1'b0);
    check("fifo_full_ready_in_hold", 32'(cmd_ready), 32'd0);
    wait_beat();
    check("fifo_ready_after_pop", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(pack_beat(1'b0, 32'h08070605, 2'd0, 1'b1, exp_user(1'b0)));
    send_lite(8'h05, 2'd0, 1'b0);
    send_lite(8'h06, 2'd0, 1'b0);
    send_lite(8'h07, 2'd0, 1'b0);
    send_lite(8'h08, 2'd0, 1'b0);
    wait_beat();
    exp_q.push_back(pack_beat(1'b1, 32'h0C0B0A09, 2'd0, 1'b1, exp_user(1'b0)));
    send_lite(8'h09, 2'd0, 1'b0);
    send_lite(8'h0A, 2'd0, 1'b0);
    send_lite(8'h0B, 2'd0, 1'b0);
    send_lite(8'h0C, 2'd0, 1'b0);
    wait_beat();

    // reset mid-burst with a second command queued
    push_cmd(1'b1, 8'd0);
    push_cmd(1'b1, 8'd0);
    send_lite(8'hAB, 2'd2, 1'b1);
    send_lite(8'hCD, 2'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid",      32'(nasti_r_valid), 32'd0);
    check("midrst_lite_ready", 32'(lite_r_ready),  32'd0);
    check("midrst_data",       nasti_r_data,       32'd0);
    check("midrst_id",         32'(nasti_r_id),    32'd0);
    check("midrst_resp",       32'(nasti_r_resp),  32'd0);
    check("midrst_user",       32'(nasti_r_user),  32'd0);
    check("midrst_cmd_ready",  32'(cmd_ready),     32'd1);
    exp_q.delete();
    tick();
    rst = 1'b0;
    any_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (nasti_r_valid || lite_r_ready) any_valid = 1'b1;
      tick();
    end
    check("postrst_quiet", 32'(any_valid), 32'd0);
    push_cmd(1'b0, 8'd0);
    exp_q.push_back(pack_beat(1'b0, 32'hF0DEBC9A, 2'd0, 1'b1, exp_user(1'b1)));
    send_lite(8'h9A, 2'd0, 1'b0);
    send_lite(8'hBC, 2'd0, 1'b0);
    send_lite(8'hDE, 2'd0, 1'b0);
    send_lite(8'hF0, 2'd0, 1'b1);
    wait_beat();

    // longest burst: 256 beats
    push_cmd(1'b1, 8'd255);
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      exp_q.push_back(pack_beat(1'b1, {bb ^ 8'hC3, 8'h5A, ~bb, bb}, bb[1:0], (b == 255), exp_user(bb[0])));
      send_lite(bb,          2'd0,    1'b0);
      send_lite(~bb,         2'd0,    1'b0);
      send_lite(8'h5A,       bb[1:0], 1'b0);
      send_lite(bb ^ 8'hC3,  2'd0,    bb[0]);
      wait_beat();
    end
    repeat (5) tick();
    check("after_long_idle_valid", 32'(nasti_r_valid), 32'd0);
    check("scoreboard_drained",    32'(exp_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nasti_lite_r_packer.md
NASTI_LITE_R_PACKER -- requirements
Module: nasti_lite_r_packer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter NASTI_DATA_WIDTH, default 32, width of the NASTI R data bus.
REQ-003 SHALL have parameter LITE_DATA_WIDTH, default 8, width of the lite R data bus; NASTI_DATA_WIDTH is an integer multiple of it.
REQ-004 SHALL have parameter USER_WIDTH, default 1, width of the user field (always > 0).
REQ-005 SHALL have parameter CMD_DEPTH, default 2, command FIFO depth (power of two, >= 1).
REQ-006 SHALL use one clock and an asynchronous, active-high reset:
 clk  in  1  clock
 rst  in  1  asynchronous active-high reset
 cmd_id  in  ID_WIDTH  burst ID
 cmd_len  in  8  NASTI beats minus 1
 cmd_valid  in  1  command valid
 cmd_ready  out  1  command FIFO not full
 lite_r_data  in  LITE_DATA_WIDTH  lite read data
 lite_r_resp  in  2  lite response
 lite_r_user  in  USER_WIDTH  lite user
 lite_r_valid  in  1  lite beat valid
 lite_r_ready  out  1  lite beat accepted
 nasti_r_id  out  ID_WIDTH  burst ID
 nasti_r_data  out  NASTI_DATA_WIDTH  packed data
 nasti_r_resp  out  2  merged response
 nasti_r_last  out  1  final beat of burst
 nasti_r_user  out  USER_WIDTH  user
 nasti_r_valid  out  1  beat valid
 nasti_r_ready  in  1  downstream accept

Function
REQ-007 SHALL define RATIO = NASTI_DATA_WIDTH/LITE_DATA_WIDTH; RATIO lite beats form one NASTI beat, first accepted beat in lane 0 (LSBs).
REQ-008 SHALL queue commands in a CMD_DEPTH FIFO; cmd_ready = !full, derived from the occupancy count only, so a push at full is refused even when a pop occurs in the same cycle.
REQ-009 SHALL implement states IDLE, FILL, HOLD.
REQ-010 IDLE: when the FIFO is non-empty, load the head's id and len, clear the beat counter, lane counter and merged resp, and go to FILL on the next cycle.
REQ-011 FILL: lite_r_ready = 1; each handshake writes a lane and increments the lane counter; on the handshake of lane RATIO-1, register the beat and go to HOLD.
REQ-012 HOLD: nasti_r_valid = 1 and lite_r_ready = 0; nasti_r_* are held stable until nasti_r_ready.
REQ-013 On a HOLD handshake, if the beat counter equals len, the block SHALL pop the command and go to IDLE; otherwise it SHALL increment the beat counter, clear the lanes and resp, and return to FILL.
REQ-014 nasti_r_last SHALL equal (beat counter == len) while in HOLD.
REQ-015 nasti_r_resp SHALL be the numeric maximum of the lite_r_resp values within one NASTI beat; resp is not carried across beats.
REQ-016 With RATIO = 1, every lite beat SHALL pass through FILL -> HOLD unchanged.
REQ-017 Throughput SHALL be RATIO+1 cycles per NASTI beat with no backpressure; the first nasti_r_valid occurs 1 cycle after the last lane is accepted.
REQ-018 The lane and beat counters SHALL be no wider than needed; len = 255 (256 beats) completes without overflow.

Reset
REQ-019 On rst, the block SHALL return to IDLE and empty the FIFO; nasti_r_valid, lite_r_ready and all nasti_r_* outputs SHALL be 0; cmd_ready SHALL be 1.
REQ-020 A reset mid-burst SHALL discard partial lanes and queued commands, with no beat emitted afterwards.

Configuration
REQ-021 With NASTI_LITE_R_PACKER_USER_EN defined, nasti_r_user SHALL equal the lite_r_user of the beat's last lane; without it, nasti_r_user SHALL be constant 0 and lite_r_user is ignored.

Structure
REQ-022 The state enum and the AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) SHALL live in shared package nasti_lite_pkg.
REQ-023 The command FIFO SHALL be the sub-module nasti_lite_cmd_fifo.

Verification (N=32, L=8, RATIO=4, CMD_DEPTH=2)
REQ-024 Command id=1, len=0, then lite beats 0x11, 0x22, 0x33, 0x44 -> one beat with data=0x44332211, last=1, id=1, resp=0.
REQ-025 len=1, eight beats, the third with resp=2 -> beat0 resp=2, last=0; beat1 resp=0, last=1.
REQ-026 nasti_r_ready held low for 5 cycles in HOLD -> nasti_r_* stable and lite_r_ready=0 throughout.
REQ-027 Three commands pushed with no data -> third sees cmd_ready=0 until the first burst's last handshake plus 1 cycle.
REQ-028 rst asserted after 2 lanes -> all outputs 0 immediately; a new len=0 burst then packs correctly.
REQ-029 Macro on: last-lane user=1 -> nasti_r_user=1; macro off -> nasti_r_user=0.
